mips_multicycle_ctrl: RTL

// Multicycle sequencer for the MIPS datapath, driven from a latched instruction register (IR).

---
 rtl/mips_multicycle_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control sequencer: walks fetch/decode/execute/memory/writeback
// states from the latched IR, stalls on memory ready and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op_in,
  input  logic [5:0]       func_in,
  input  logic             zero_in,
  input  logic             mem_ready_in,
  output logic             pcWrite_out,
  output logic [1:0]       pcSource_out,
  output logic             iorD_out,
  output logic             memRead_out,
  output logic             memWrite_out,
  output logic             irWrite_out,
  output logic             regDst_out,
  output logic             memToReg_out,
  output logic             regWrite_out,
  output logic             extCntrl_out,
  output logic             aluSrcA_out,
  output logic [1:0]       aluSrcB_out,
  output logic [3:0]       ALUCntrl_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] retired_out,
  output logic [3:0]       state_out
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd13,
    S_HALT    = 4'd14
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             r_legal;
  logic [3:0]       r_alu, i_alu;
  logic             i_ext;

  logic       pc_write, ir_write, mem_write, reg_write, illegal;
  logic       iord, mem_read, reg_dst, mem_to_reg, ext_cntrl, src_a;
  logic [1:0] pc_source, src_b;
  logic [3:0] alu_cntrl;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (func_in)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_legal = 1'b0;
    endcase
    i_ext = 1'b1;
    i_alu = ALU_ADD;
    case (op_in)
      6'h0A:   i_alu = ALU_SLT;
      6'h0C:   begin i_alu = ALU_AND; i_ext = 1'b0; end
      6'h0D:   begin i_alu = ALU_OR;  i_ext = 1'b0; end
      default: i_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready_in) state_d = S_DECODE;
      S_DECODE: begin
        case (op_in)
          6'h00: begin
            if (func_in == 6'h08) state_d = S_JR;
            else if (r_legal)     state_d = S_EXEC;
            else                  state_d = S_ILLEGAL;
          end
          6'h23, 6'h2B:               state_d = S_MEMADR;
          6'h04, 6'h05:               state_d = S_BRANCH;
          6'h02:                      state_d = S_JUMP;
          6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = S_IMMEX;
          default:                    state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op_in == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_in) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_in) begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JR: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ILLEGAL: state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    ext_cntrl  = 1'b1;
    src_a      = 1'b0;
    src_b      = 2'b00;
    alu_cntrl  = ALU_AND;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        src_b     = 2'b01;
        alu_cntrl = ALU_ADD;
        ir_write  = mem_ready_in;
        pc_write  = mem_ready_in;
      end
      S_DECODE: begin src_b = 2'b11; alu_cntrl = ALU_ADD; end
      S_MEMADR: begin src_a = 1'b1; src_b = 2'b10; alu_cntrl = ALU_ADD; end
      S_MEMRD:  begin iord = 1'b1; mem_read = 1'b1; end
      S_MEMWB:  begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; mem_write = 1'b1; end
      S_EXEC:   begin src_a = 1'b1; alu_cntrl = r_alu; end
      S_ALUWB:  begin reg_dst = 1'b1; reg_write = 1'b1; end
      S_BRANCH: begin
        src_a     = 1'b1;
        alu_cntrl = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = ((op_in == 6'h04) && zero_in) || ((op_in == 6'h05) && !zero_in);
      end
      S_JUMP:   begin pc_source = 2'b10; pc_write = 1'b1; end
      S_JR:     begin pc_source = 2'b11; pc_write = 1'b1; end
      S_IMMEX:  begin src_a = 1'b1; src_b = 2'b10; alu_cntrl = i_alu; ext_cntrl = i_ext; end
      S_IMMWB:  begin reg_write = 1'b1; alu_cntrl = i_alu; ext_cntrl = i_ext; end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  // Architectural-state enables are suppressed for the whole reset cycle,
  // even though the decoded state may still be mid-instruction.
  assign pcWrite_out  = pc_write  & ~reset;
  assign irWrite_out  = ir_write  & ~reset;
  assign memWrite_out = mem_write & ~reset;
  assign regWrite_out = reg_write & ~reset;
  assign illegal_out  = illegal   & ~reset;

  assign pcSource_out  = pc_source;
  assign iorD_out      = iord;
  assign memRead_out   = mem_read;
  assign regDst_out    = reg_dst;
  assign memToReg_out  = mem_to_reg;
  assign extCntrl_out  = ext_cntrl;
  assign aluSrcA_out   = src_a;
  assign aluSrcB_out   = src_b;
  assign ALUCntrl_out  = alu_cntrl;
  assign retired_out   = retired_q;
  assign state_out     = state_q;

endmodule
